// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_arbiter
// Brief    : Clears the 4x8 register file after reset, then shares its single
//            write port round-robin between NUM_REQ writeback requesters.
// Revision : 1.0
// ============================================================================
module rf_write_arbiter #(
    parameter int          NUM_REQ   = 3,
    parameter int          DW        = 8,
    parameter int          AW        = 2,
    parameter logic [DW-1:0] CLEAR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [AW-1:0]         rf_write_reg,
    output logic [DW-1:0]         rf_write_data,
    output logic                  rf_write_en,
    output logic                  init_done,
    output logic [7:0]            conflict_cnt
);

    localparam int            PW       = $clog2(NUM_REQ);
    localparam logic [PW:0]   NREQ_W   = (PW+1)'(NUM_REQ);
    localparam logic [AW-1:0] LAST_REG = {AW{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              r_state;
    logic [AW-1:0]       r_clr_cnt;
    logic [PW-1:0]       r_rr_ptr;
    logic                r_wr_en;
    logic [AW-1:0]       r_wr_reg;
    logic [DW-1:0]       r_wr_data;
    logic [7:0]          r_conflict_cnt;

    logic [NUM_REQ-1:0]  w_rot;
    logic [PW-1:0]       w_off;
    logic                w_any;
    logic [PW:0]         w_sum;
    logic [PW-1:0]       w_winner;
    logic [PW:0]         w_nsum;
    logic [PW-1:0]       w_next_ptr;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_xfer;
    logic                w_conflict;

    // Rotate the request vector so bit 0 is the requester at rr_ptr; the lowest
    // set bit of the rotated vector is then the round-robin winner's offset.
    always_comb begin
        w_rot = NUM_REQ'({req_valid, req_valid} >> r_rr_ptr);
        w_off = '0;
        w_any = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = PW'(j);
                w_any = 1'b1;
            end
        end

        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= NREQ_W) begin
            w_sum = w_sum - NREQ_W;
        end
        w_winner = w_sum[PW-1:0];

        w_nsum = {1'b0, w_winner} + (PW+1)'(1);
        if (w_nsum >= NREQ_W) begin
            w_nsum = '0;
        end
        w_next_ptr = w_nsum[PW-1:0];

        for (int i = 0; i < NUM_REQ; i++) begin
            w_grant[i] = w_any && (w_winner == PW'(i));
        end
    end

    assign req_ready  = (r_state == ST_RUN && !reset) ? w_grant : '0;
    assign w_xfer     = (r_state == ST_RUN) && w_any;
    assign w_conflict = ($countones(req_valid) > 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_CLEAR;
            r_clr_cnt      <= '0;
            r_rr_ptr       <= '0;
            r_wr_en        <= 1'b0;
            r_wr_reg       <= '0;
            r_wr_data      <= '0;
            r_conflict_cnt <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_wr_en   <= 1'b1;
                    r_wr_reg  <= r_clr_cnt;
                    r_wr_data <= CLEAR_VAL;
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == LAST_REG) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Address/data hold when idle; only the enable drops.
                    r_wr_en <= w_xfer;
                    if (w_xfer) begin
                        r_wr_reg  <= req_addr[w_winner*AW +: AW];
                        r_wr_data <= req_data[w_winner*DW +: DW];
                        r_rr_ptr  <= w_next_ptr;
                    end
                    if (w_conflict && r_conflict_cnt != 8'hFF) begin
                        r_conflict_cnt <= r_conflict_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    assign rf_write_en   = r_wr_en;
    assign rf_write_reg  = r_wr_reg;
    assign rf_write_data = r_wr_data;
    assign init_done     = (r_state == ST_RUN);
    assign conflict_cnt  = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_arbiter
// Brief    : Directed bench for rf_write_arbiter with a write scoreboard.
// Revision : 1.0
// ============================================================================
module tb_rf_write_arbiter;

    localparam int NUM_REQ = 3;
    localparam int DW      = 8;
    localparam int AW      = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ*AW-1:0] req_addr = '0;
    logic [NUM_REQ*DW-1:0] req_data = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [AW-1:0]         rf_write_reg;
    logic [DW-1:0]         rf_write_data;
    logic                  rf_write_en;
    logic                  init_done;
    logic [7:0]            conflict_cnt;

    rf_write_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DW        (DW),
        .AW        (AW),
        .CLEAR_VAL (8'h00)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_write_en   (rf_write_en),
        .init_done     (init_done),
        .conflict_cnt  (conflict_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic        m_run = 1'b0;
    logic [1:0]  m_clr = '0;
    int          m_rr = 0;
    logic [7:0]  m_cc = '0;
    logic [1:0]  m_last_reg = '0;
    logic [7:0]  m_last_data = '0;
    logic [9:0]  sb[$];
    int          last_grant = -1;

    // Register file behind the write port, capturing on the negedge
    logic [7:0]  rf_mem [4];
    always @(negedge clk) begin
        if (rf_write_en === 1'b1) rf_mem[rf_write_reg] <= rf_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
        req_valid[i]         = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // One clock: predict grant and write, check ready, advance, check outputs.
    task automatic cycle();
        logic [2:0] eg;
        logic       pushed;
        logic [9:0] e;
        eg = '0;
        pushed = 1'b0;
        last_grant = -1;
        #1;
        if (reset) begin
        end else if (!m_run) begin
            sb.push_back({m_clr, 8'h00});
            pushed = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (m_rr + k) % NUM_REQ;
                if (last_grant < 0 && req_valid[idx]) begin
                    eg[idx] = 1'b1;
                    last_grant = idx;
                end
            end
            if (last_grant >= 0) begin
                sb.push_back({req_addr[last_grant*AW +: AW], req_data[last_grant*DW +: DW]});
                pushed = 1'b1;
                m_rr = (last_grant + 1) % NUM_REQ;
            end
            if ($countones(req_valid) > 1 && m_cc != 8'hFF) m_cc++;
        end
        chk("req_ready", 32'(req_ready), 32'(eg));
        @(posedge clk);
        #1;
        if (reset) begin
            m_run = 1'b0; m_clr = '0; m_rr = 0; m_cc = '0;
            m_last_reg = '0; m_last_data = '0;
            sb.delete();
        end else if (!m_run) begin
            if (m_clr == 2'd3) m_run = 1'b1;
            m_clr++;
        end
        chk("write_en", 32'(rf_write_en), 32'(pushed));
        if (pushed) begin
            e = sb.pop_front();
            chk("write_reg", 32'(rf_write_reg), 32'(e[9:8]));
            chk("write_data", 32'(rf_write_data), 32'(e[7:0]));
            m_last_reg  = e[9:8];
            m_last_data = e[7:0];
        end else begin
            chk("hold_reg", 32'(rf_write_reg), 32'(m_last_reg));
            chk("hold_data", 32'(rf_write_data), 32'(m_last_data));
        end
        chk("init_done", 32'(init_done), 32'(m_run));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cc));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        int wait_cnt;
        logic got1;

        // Reset, then the four clear writes
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        repeat (4) cycle();
        cycle();

        // Single request from the ALU
        set_req(0, 2'd2, 8'hA5);
        cycle();
        chk("grant_req0", 32'(last_grant), 32'd0);
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("rf_reg2", 32'(rf_mem[2]), 32'h0000_00A5);
        cycle();

        // Bring rr_ptr back to 0 with a single req2 write
        set_req(2, 2'd1, 8'h22);
        cycle();
        req_valid = '0;

        // All three valid: strict 0,1,2,0,1,2 rotation
        set_req(0, 2'd0, 8'h10);
        set_req(1, 2'd1, 8'h11);
        set_req(2, 2'd3, 8'h12);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_order", 32'(last_grant), 32'(k % NUM_REQ));
            if (last_grant >= 0) req_data[last_grant*DW +: DW] += 8'h20;
        end
        req_valid = '0;

        // Req1 held while req0 toggles
        set_req(1, 2'd3, 8'h77);
        wait_cnt = 0;
        got1 = 1'b0;
        for (int t = 0; t < 8 && !got1; t++) begin
            req_valid[0] = (t % 2 == 0);
            cycle();
            if (last_grant == 1) got1 = 1'b1;
            else wait_cnt++;
        end
        chk("req1_granted", 32'(got1), 32'd1);
        chk("req1_bounded", 32'(wait_cnt < NUM_REQ), 32'd1);
        req_valid = '0;
        cycle();

        // Reset mid-RUN with req2 pending; CLEAR must repeat before its grant
        set_req(2, 2'd2, 8'hC3);
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        repeat (4) cycle();
        cycle();
        chk("req2_after_clear", 32'(last_grant), 32'd2);
        req_valid = '0;
        cycle();

        // Sustained contention saturates conflict_cnt
        set_req(0, 2'd0, 8'h01);
        set_req(1, 2'd1, 8'h02);
        set_req(2, 2'd2, 8'h03);
        for (int k = 0; k < 300; k++) begin
            cycle();
            if (last_grant >= 0) req_data[last_grant*DW +: DW] += 8'h03;
        end
        chk("cc_saturated", 32'(conflict_cnt), 32'h0000_00FF);
        req_valid = '0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
